// File: rtl/line_window_pkg.sv
// Shared types and size derivations for the line-buffer window generator.
package line_window_pkg;

    // Read-side sequencing: wait for enough lines, stream one row of windows, retire the oldest line.
    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_READ   = 2'd1,
        ST_RETIRE = 2'd2
    } lw_state_t;

    // One spare buffer beyond the window height so writing never collides with reading.
    function automatic int calc_num_buf(input int win_k);
        return win_k + 1;
    endfunction

    // Flattened KxK window width in bits.
    function automatic int calc_win_w(input int win_k, input int pix_w);
        return win_k * win_k * pix_w;
    endfunction

endpackage

// File: rtl/line_window_unit_ram.sv
// Single image-line buffer: one write port, WIN_K adjacent pixels read per cycle.
module line_buffer_ram
    import line_window_pkg::*;
#(
    parameter int IMG_WIDTH = 512,
    parameter int PIX_W     = 8,
    parameter int WIN_K     = 3
) (
    input  logic                         clk,
    input  logic                         i_we,
    input  logic [$clog2(IMG_WIDTH)-1:0] i_waddr,
    input  logic [PIX_W-1:0]             i_wdata,
    input  logic                         i_re,
    input  logic [$clog2(IMG_WIDTH)-1:0] i_raddr,
    output logic [WIN_K*PIX_W-1:0]       o_rdata
);

    localparam int AW = $clog2(IMG_WIDTH);

    logic [PIX_W-1:0]       r_mem [IMG_WIDTH];
    logic [WIN_K*PIX_W-1:0] r_rdata_p1;

    // Pixel store at the write column.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // ---- stage p1: registered read of columns raddr..raddr+WIN_K-1, held when not enabled ----
    always_ff @(posedge clk) begin
        if (i_re) begin
            for (int c = 0; c < WIN_K; c++) begin
                r_rdata_p1[c*PIX_W +: PIX_W] <= r_mem[i_raddr + AW'(c)];
            end
        end
    end

    assign o_rdata = r_rdata_p1;

endmodule

// File: rtl/line_window_unit.sv
// Raster pixel stream in, sliding KxK windows out, using WIN_K+1 rotating line buffers.
module line_window_unit
    import line_window_pkg::*;
#(
    parameter int IMG_WIDTH = 512,
    parameter int PIX_W     = 8,
    parameter int WIN_K     = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  pixel_valid,
    input  logic [PIX_W-1:0]                      pixel_in,
    output logic                                  in_ready,
    output logic [calc_win_w(WIN_K, PIX_W)-1:0]   window_out,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  line_request
);

    localparam int NUM_BUF = calc_num_buf(WIN_K);
    localparam int WIN_W   = calc_win_w(WIN_K, PIX_W);
    localparam int ROW_W   = WIN_K * PIX_W;
    localparam int CW      = $clog2(IMG_WIDTH);
    localparam int BW      = $clog2(NUM_BUF);
    localparam int LW      = $clog2(NUM_BUF + 1);

    localparam logic [CW-1:0] WR_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] RD_LAST  = CW'(IMG_WIDTH - WIN_K);
    localparam logic [BW-1:0] BUF_LAST = BW'(NUM_BUF - 1);

    lw_state_t         r_state;
    lw_state_t         w_state_nxt;
    logic [CW-1:0]     r_wr_col;
    logic [CW-1:0]     r_rd_col;
    logic [BW-1:0]     r_wr_idx;
    logic [BW-1:0]     r_rd_base;
    logic [LW-1:0]     r_lines;
    logic              r_all_issued;
    logic              r_vld_p1;
    logic              r_last_p1;
    logic              r_vld_p2;
    logic              r_last_p2;
    logic [WIN_W-1:0]  r_window_p2;

    logic              w_accept;
    logic              w_wr_wrap;
    logic              w_adv;
    logic              w_issue;
    logic              w_issue_last;
    logic              w_last_accept;
    logic              w_read_st;
    logic              w_retire;
    logic [ROW_W-1:0]  w_rdata_p1 [NUM_BUF];
    logic [WIN_W-1:0]  w_window_p1;

    // Physical buffer holding window row 'row' (0 = oldest), rotating from the read base.
    function automatic logic [BW-1:0] buf_of_row(input logic [BW-1:0] base, input int row);
        logic [BW:0] s;
        s = {1'b0, base} + (BW+1)'(row);
        if (s >= (BW+1)'(NUM_BUF)) begin
            s = s - (BW+1)'(NUM_BUF);
        end
        return s[BW-1:0];
    endfunction

    assign in_ready      = (r_lines < LW'(NUM_BUF));
    assign w_accept      = pixel_valid && in_ready;
    assign w_wr_wrap     = w_accept && (r_wr_col == WR_LAST);
    assign w_adv         = !r_vld_p2 || out_ready;
    assign w_issue       = w_read_st && w_adv && !r_all_issued;
    assign w_issue_last  = w_issue && (r_rd_col == RD_LAST);
    assign w_last_accept = r_vld_p2 && out_ready && r_last_p2;

    // Write pointer: column within the line, then rotate to the next buffer on wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_col <= '0;
            r_wr_idx <= '0;
        end else if (w_accept) begin
            if (w_wr_wrap) begin
                r_wr_col <= '0;
                r_wr_idx <= (r_wr_idx == BUF_LAST) ? '0 : r_wr_idx + BW'(1);
            end else begin
                r_wr_col <= r_wr_col + CW'(1);
            end
        end
    end

    // Count of complete lines held; a simultaneous line completion and retire cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lines <= '0;
        end else begin
            case ({w_wr_wrap, w_retire})
                2'b10:   r_lines <= r_lines + LW'(1);
                2'b01:   r_lines <= r_lines - LW'(1);
                default: r_lines <= r_lines;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: read once WIN_K lines are present, retire after the row's last window leaves.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FILL:   if (r_lines >= LW'(WIN_K)) w_state_nxt = ST_READ;
            ST_READ:   if (w_last_accept)         w_state_nxt = ST_RETIRE;
            ST_RETIRE: w_state_nxt = ST_FILL;
            default:   w_state_nxt = ST_FILL;
        endcase
    end

    // FSM outputs.
    always_comb begin
        w_read_st    = (r_state == ST_READ);
        w_retire     = (r_state == ST_RETIRE);
        line_request = w_retire;
    end

    // Read column sweep across the row and read-base rotation on retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_col     <= '0;
            r_all_issued <= 1'b0;
            r_rd_base    <= '0;
        end else begin
            if (w_issue) begin
                if (w_issue_last) begin
                    r_rd_col     <= '0;
                    r_all_issued <= 1'b1;
                end else begin
                    r_rd_col <= r_rd_col + CW'(1);
                end
            end
            if (w_retire) begin
                r_all_issued <= 1'b0;
                r_rd_base    <= (r_rd_base == BUF_LAST) ? '0 : r_rd_base + BW'(1);
            end
        end
    end

    // ---- stage p0 -> p1: every buffer is addressed at the same read column ----
    for (genvar g = 0; g < NUM_BUF; g++) begin : g_buf
        line_buffer_ram #(
            .IMG_WIDTH (IMG_WIDTH),
            .PIX_W     (PIX_W),
            .WIN_K     (WIN_K)
        ) u_ram (
            .clk     (clk),
            .i_we    (w_accept && (r_wr_idx == BW'(g))),
            .i_waddr (r_wr_col),
            .i_wdata (pixel_in),
            .i_re    (w_issue),
            .i_raddr (r_rd_col),
            .o_rdata (w_rdata_p1[g])
        );
    end

    // Order buffer outputs into window rows, oldest line at row 0.
    always_comb begin
        w_window_p1 = '0;
        for (int r = 0; r < WIN_K; r++) begin
            w_window_p1[r*ROW_W +: ROW_W] = w_rdata_p1[buf_of_row(r_rd_base, r)];
        end
    end

    // ---- stage p1 -> p2: valid/last tags travel with the data; whole pipe freezes on stall ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1  <= 1'b0;
            r_last_p1 <= 1'b0;
            r_vld_p2  <= 1'b0;
            r_last_p2 <= 1'b0;
        end else if (w_adv) begin
            r_vld_p1  <= w_issue;
            r_last_p1 <= w_issue_last;
            r_vld_p2  <= r_vld_p1;
            r_last_p2 <= r_last_p1;
        end
    end

    // Output window register, loaded only when a fetched window moves forward.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_window_p2 <= '0;
        end else if (w_adv && r_vld_p1) begin
            r_window_p2 <= w_window_p1;
        end
    end

    assign window_out = r_window_p2;
    assign out_valid  = r_vld_p2;

endmodule

// File: tb/tb_line_window_unit.sv
// Scoreboard bench: an 8-wide 3x3 instance and a 16-wide 5x5 instance, pixel = row*16+col.
module tb_line_window_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         a_rst = 1'b1, a_pv = 1'b0, a_ordy = 1'b1;
    logic [7:0]   a_pin = '0;
    logic         a_in_ready, a_ov, a_lr;
    logic [71:0]  a_win;

    logic         b_rst = 1'b1, b_pv = 1'b0, b_ordy = 1'b1;
    logic [7:0]   b_pin = '0;
    logic         b_in_ready, b_ov, b_lr;
    logic [199:0] b_win;

    line_window_unit #(.IMG_WIDTH(8), .PIX_W(8), .WIN_K(3)) u_dut_a (
        .clk(clk), .rst(a_rst), .pixel_valid(a_pv), .pixel_in(a_pin), .in_ready(a_in_ready),
        .window_out(a_win), .out_valid(a_ov), .out_ready(a_ordy), .line_request(a_lr)
    );

    line_window_unit #(.IMG_WIDTH(16), .PIX_W(8), .WIN_K(5)) u_dut_b (
        .clk(clk), .rst(b_rst), .pixel_valid(b_pv), .pixel_in(b_pin), .in_ready(b_in_ready),
        .window_out(b_win), .out_valid(b_ov), .out_ready(b_ordy), .line_request(b_lr)
    );

    int n_total = 0;
    int n_pass  = 0;
    logic [199:0] a_q[$];
    logic [199:0] b_q[$];
    int a_rcvd = 0, b_rcvd = 0, a_lr_cnt = 0, b_lr_cnt = 0;
    bit a_saw_not_ready = 0;
    bit t3_done = 0;

    task automatic check_v(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Expected window whose top-left pixel is (row0, col0); row r col c at byte r*k+c.
    function automatic logic [199:0] mk_win(input int k, input int row0, input int col0);
        logic [199:0] w = '0;
        for (int r = 0; r < k; r++)
            for (int c = 0; c < k; c++)
                w[(r*k+c)*8 +: 8] = 8'((row0 + r) * 16 + col0 + c);
        return w;
    endfunction

    task automatic push_row(input bit is_b, input int row0);
        int k = is_b ? 5 : 3;
        int w = is_b ? 16 : 8;
        for (int c = 0; c <= w - k; c++) begin
            if (is_b) b_q.push_back(mk_win(k, row0, c));
            else      a_q.push_back(mk_win(k, row0, c));
        end
    endtask

    task automatic send_px(input bit is_b, input logic [7:0] v);
        int n = 0;
        if (is_b) begin b_pv = 1'b1; b_pin = v; end
        else      begin a_pv = 1'b1; a_pin = v; end
        while (!(is_b ? b_in_ready : a_in_ready) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) check_i("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        a_pv = 1'b0;
        b_pv = 1'b0;
    endtask

    task automatic send_rows(input bit is_b, input int row0, input int nrows);
        int w = is_b ? 16 : 8;
        for (int r = 0; r < nrows; r++)
            for (int c = 0; c < w; c++)
                send_px(is_b, 8'((row0 + r) * 16 + c));
    endtask

    task automatic drain(input bit is_b, input string name);
        int n = 0;
        while ((is_b ? b_q.size() : a_q.size()) != 0 && n < 400) begin
            @(posedge clk); #1; n++;
        end
        check_i(name, is_b ? b_q.size() : a_q.size(), 0);
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic reset_a();
        a_rst = 1'b1; a_pv = 1'b0; a_ordy = 1'b1;
        repeat (2) @(posedge clk);
        #1 a_rst = 1'b0;
        a_q.delete();
        a_rcvd = 0; a_lr_cnt = 0; a_saw_not_ready = 0;
    endtask

    // Monitor: pop and compare on every handshake, check hold-while-stalled, count line requests.
    initial begin
        logic [199:0] exp;
        bit a_stall_prev = 0, b_stall_prev = 0;
        logic [71:0]  a_held = '0;
        logic [199:0] b_held = '0;
        forever begin
            @(negedge clk);
            if (a_rst) a_stall_prev = 0;
            else begin
                if (a_stall_prev) begin
                    check_i("a_hold_valid", int'(a_ov), 1);
                    check_v("a_hold_data", 200'(a_win), 200'(a_held));
                end
                if (a_ov && a_ordy) begin
                    if (a_q.size() == 0) begin
                        n_total++;
                        $display("FAIL a_extra_window: got %h expected none", a_win);
                    end else begin
                        exp = a_q.pop_front();
                        check_v("a_window", 200'(a_win), exp);
                        a_rcvd++;
                    end
                end
                a_stall_prev = a_ov && !a_ordy;
                a_held = a_win;
                if (a_lr) a_lr_cnt++;
                if (!a_in_ready) a_saw_not_ready = 1;
            end
            if (b_rst) b_stall_prev = 0;
            else begin
                if (b_stall_prev) check_v("b_hold_data", b_win, b_held);
                if (b_ov && b_ordy) begin
                    if (b_q.size() == 0) begin
                        n_total++;
                        $display("FAIL b_extra_window: got %h expected none", b_win);
                    end else begin
                        exp = b_q.pop_front();
                        check_v("b_window", b_win, exp);
                        b_rcvd++;
                    end
                end
                b_stall_prev = b_ov && !b_ordy;
                b_held = b_win;
                if (b_lr) b_lr_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int pat [4] = '{1, 0, 0, 1};
        @(posedge clk); #1;

        // Three rows, free-running output: reset state, latency, six windows, one line request
        reset_a();
        check_i("a_rst_in_ready", int'(a_in_ready), 1);
        check_i("a_rst_out_valid", int'(a_ov), 0);
        check_i("a_rst_line_req", int'(a_lr), 0);
        check_v("a_rst_window", 200'(a_win), '0);
        push_row(0, 0);
        send_rows(0, 0, 3);
        n = 0;
        while (!a_ov && n < 20) begin @(posedge clk); #1; n++; end
        check_i("a_first_latency", n, 3);
        drain(0, "a_t1_drain");
        check_i("a_t1_rcvd", a_rcvd, 6);
        check_i("a_t1_line_req", a_lr_cnt, 1);

        // Five rows back to back: input stalls when all buffers fill, 18 windows, nothing lost
        reset_a();
        push_row(0, 0); push_row(0, 1); push_row(0, 2);
        send_rows(0, 0, 5);
        drain(0, "a_t2_drain");
        check_i("a_t2_saw_not_ready", int'(a_saw_not_ready), 1);
        check_i("a_t2_rcvd", a_rcvd, 18);
        check_i("a_t2_line_req", a_lr_cnt, 3);

        // Output back-pressure pattern 1,0,0,1 while a row is read out
        reset_a();
        push_row(0, 0);
        t3_done = 0;
        fork
            begin
                send_rows(0, 0, 3);
                drain(0, "a_t3_drain");
                t3_done = 1;
            end
            begin
                for (int i = 0; i < 1000 && !t3_done; i++) begin
                    a_ordy = pat[i % 4] != 0;
                    @(posedge clk); #1;
                end
            end
        join
        a_ordy = 1'b1;
        check_i("a_t3_rcvd", a_rcvd, 6);
        check_i("a_t3_line_req", a_lr_cnt, 1);

        // Last pixel of row 3 lands on the retire cycle: line count must stay at 3
        reset_a();
        push_row(0, 0); push_row(0, 1);
        send_rows(0, 0, 3);
        for (int c = 0; c < 7; c++) send_px(0, 8'(3 * 16 + c));
        n = 0;
        while (!a_lr && n < 50) begin @(posedge clk); #1; n++; end
        check_i("a_t4_retire_seen", int'(a_lr), 1);
        a_pv = 1'b1; a_pin = 8'h37;
        @(posedge clk); #1;
        a_pv = 1'b0;
        check_i("a_t4_in_ready_after", int'(a_in_ready), 1);
        drain(0, "a_t4_drain");
        check_i("a_t4_rcvd", a_rcvd, 12);
        check_i("a_t4_line_req", a_lr_cnt, 2);

        // Reset in the middle of reading, then fresh rows 8..10 only
        reset_a();
        push_row(0, 0);
        send_rows(0, 0, 3);
        n = 0;
        while (a_rcvd < 3 && n < 50) begin @(posedge clk); #1; n++; end
        check_i("a_t5_pre_rcvd", a_rcvd, 3);
        a_rst = 1'b1;
        @(posedge clk); #1;
        a_rst = 1'b0;
        a_q.delete(); a_rcvd = 0; a_lr_cnt = 0;
        check_i("a_t5_out_valid", int'(a_ov), 0);
        check_i("a_t5_line_req", int'(a_lr), 0);
        check_i("a_t5_in_ready", int'(a_in_ready), 1);
        push_row(0, 8);
        send_rows(0, 8, 3);
        drain(0, "a_t5_drain");
        check_i("a_t5_rcvd", a_rcvd, 6);
        check_i("a_t5_line_req_cnt", a_lr_cnt, 1);

        // 5x5 window over 16-pixel rows: 12 windows of 200 bits
        b_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 b_rst = 1'b0;
        b_lr_cnt = 0; b_rcvd = 0;
        check_i("b_rst_in_ready", int'(b_in_ready), 1);
        check_i("b_rst_out_valid", int'(b_ov), 0);
        check_v("b_rst_window", b_win, '0);
        push_row(1, 0);
        send_rows(1, 0, 5);
        n = 0;
        while (!b_ov && n < 20) begin @(posedge clk); #1; n++; end
        check_i("b_first_latency", n, 3);
        drain(1, "b_drain");
        check_i("b_rcvd", b_rcvd, 12);
        check_i("b_line_req", b_lr_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/line_window_unit.md
LINE_WINDOW_UNIT -- requirements
Module: line_window_unit

Interface
REQ-001 Parameter IMG_WIDTH, default 512: pixels per image row; SHALL be >= WIN_K.
REQ-002 Parameter PIX_W, default 8: bits per pixel.
REQ-003 Parameter WIN_K, default 3: window height and width; SHALL be >= 2.
REQ-004 Derived NUM_BUF = WIN_K+1 line buffers; WIN_W = WIN_K*WIN_K*PIX_W (72 at defaults).
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 pixel_valid  in  1  input pixel present.
REQ-008 pixel_in  in  PIX_W  input pixel, raster order.
REQ-009 in_ready  out  1  unit can accept a pixel this cycle.
REQ-010 window_out  out  WIN_W  KxK window: row r (0 = oldest line) at bits [r*WIN_K*PIX_W +: WIN_K*PIX_W]; within a row, column c (0 = leftmost) at [c*PIX_W +: PIX_W].
REQ-011 out_valid  out  1  window_out holds a valid window.
REQ-012 out_ready  in  1  downstream accepts window_out.
REQ-013 line_request  out  1  one-cycle pulse: one output row finished, oldest line retired.

Function
REQ-014 A pixel SHALL be accepted only when pixel_valid && in_ready; it is written at the write column of the current write buffer.
REQ-015 The write column SHALL wrap from IMG_WIDTH-1 to 0; on that wrap the write buffer index SHALL advance modulo NUM_BUF and lines_stored SHALL increment.
REQ-016 in_ready SHALL be 1 exactly when lines_stored < NUM_BUF; it is combinational from the registered count.
REQ-017 The FSM SHALL have states FILL, READ and RETIRE.
REQ-018 FILL -> READ when lines_stored >= WIN_K; otherwise FILL holds.
REQ-019 In READ, each read step SHALL fetch columns rd_col..rd_col+WIN_K-1 from the WIN_K buffers starting at the oldest.
REQ-020 rd_col SHALL run 0..IMG_WIDTH-WIN_K, giving IMG_WIDTH-WIN_K+1 windows per row, with no padding.
REQ-021 A read step SHALL advance only when the output stage is free: !out_valid || out_ready.
REQ-022 Buffer reads SHALL be 1-cycle synchronous; window_out/out_valid registered; first out_valid 2 cycles after entering READ with out_ready high.
REQ-023 While out_valid && !out_ready, window_out SHALL hold stable and no window SHALL be dropped or duplicated.
REQ-024 After the last window of a row is accepted, the FSM SHALL enter RETIRE for 1 cycle.
REQ-025 RETIRE SHALL pulse line_request, advance the read base index modulo NUM_BUF, decrement lines_stored and return to FILL.
REQ-026 If a line-write wrap and a RETIRE occur in the same cycle, lines_stored SHALL remain unchanged.
REQ-027 Writes SHALL continue during READ/RETIRE into the free buffer and never target a buffer being read.
REQ-028 All counters SHALL be sized by $clog2 of their range; no silent truncation at any legal parameter value.

Reset
REQ-029 On rst: FSM = FILL; write column, read column, write index, read base and lines_stored = 0; out_valid = 0; line_request = 0; window_out = 0.
REQ-030 Reset mid-row or mid-READ SHALL discard all stored lines; buffer RAM contents need not clear.
REQ-031 in_ready SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-032 Shared package line_window_pkg SHALL hold the FSM state enum and the WIN_W/NUM_BUF derivation functions.
REQ-033 Sub-module line_buffer_ram: one IMG_WIDTH x PIX_W buffer with 1 write port and WIN_K-wide 1-cycle read; instantiated NUM_BUF times via generate.

Verification (IMG_WIDTH=8, WIN_K=3, PIX_W=8, pixel value = row*16+col)
REQ-034 Stream 24 pixels with out_ready=1 -> 6 windows; first window rows {0x00,01,02},{0x10,11,12},{0x20,21,22}, first out_valid 2 cycles after READ entry; one line_request after the 6th window.
REQ-035 Continuous stream of 5 rows with out_ready=1 -> in_ready deasserts when lines_stored=4; no pixel lost; 18 windows total after rows 3-5 processed.
REQ-036 Toggle out_ready 1,0,0,1 during READ -> window_out stable while stalled; exact ordered sequence of 6 windows per row.
REQ-037 Align the 8th pixel of row 3 with the RETIRE cycle -> lines_stored unchanged; next row windows correct.
REQ-038 Assert rst mid-READ after 3 windows -> next cycle out_valid=0, line_request=0, in_ready=1; fresh 3 rows give windows from new data only.
REQ-039 Rerun REQ-034 with WIN_K=5, IMG_WIDTH=16 -> 12 windows per row, window_out 200 bits, correct lane mapping.
